// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX slice: widths, the packed control bundle
// and the all-zero bubble constant.
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int ALU_OP_W = 3;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src;
        logic                reg_dst;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard equation: a load in EX whose destination rt is read by the
// instruction currently in ID. $0 never creates a dependency.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_hz
);

    // rt is compared even for I-type consumers; the extra stall is harmless.
    assign o_hz = i_ex_mem_read && (i_ex_rt != '0) &&
                  ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock: stalls PC and IF/ID, injects
// bubbles for STALL_CYCLES edges per hazard, and squashes on a branch flush.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W       = pipe_pkg::DATA_W,
    parameter int STALL_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REG_W-1:0]    id_rs_i,
    input  logic [REG_W-1:0]    id_rt_i,
    input  logic [REG_W-1:0]    id_rd_i,
    input  logic [DATA_W-1:0]   id_rs_data_i,
    input  logic [DATA_W-1:0]   id_rt_data_i,
    input  logic [DATA_W-1:0]   id_imm_i,
    input  logic [DATA_W-1:0]   id_pc4_i,
    input  logic                id_reg_write_i,
    input  logic                id_mem_to_reg_i,
    input  logic                id_mem_read_i,
    input  logic                id_mem_write_i,
    input  logic                id_alu_src_i,
    input  logic                id_reg_dst_i,
    input  logic                id_branch_i,
    input  logic [ALU_OP_W-1:0] id_alu_op_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic [REG_W-1:0]    ex_rs_o,
    output logic [REG_W-1:0]    ex_rt_o,
    output logic [REG_W-1:0]    ex_rd_o,
    output logic [DATA_W-1:0]   ex_rs_data_o,
    output logic [DATA_W-1:0]   ex_rt_data_o,
    output logic [DATA_W-1:0]   ex_imm_o,
    output logic [DATA_W-1:0]   ex_pc4_o,
    output logic                ex_reg_write_o,
    output logic                ex_mem_to_reg_o,
    output logic                ex_mem_read_o,
    output logic                ex_mem_write_o,
    output logic                ex_alu_src_o,
    output logic                ex_reg_dst_o,
    output logic                ex_branch_o,
    output logic [ALU_OP_W-1:0] ex_alu_op_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]        r_state;
    logic [1:0]        r_cnt;
    logic [REG_W-1:0]  r_rs, r_rt, r_rd;
    logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm, r_pc4;
    ctrl_t             r_ctrl;

    ctrl_t w_id_ctrl;
    logic  w_hz;
    logic  w_bubble;

    assign w_id_ctrl = '{reg_write:  id_reg_write_i,
                         mem_to_reg: id_mem_to_reg_i,
                         mem_read:   id_mem_read_i,
                         mem_write:  id_mem_write_i,
                         alu_src:    id_alu_src_i,
                         reg_dst:    id_reg_dst_i,
                         branch:     id_branch_i,
                         alu_op:     id_alu_op_i};

    hazard_detect u_hazard_detect (
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rt       (r_rt),
        .i_id_rs       (id_rs_i),
        .i_id_rt       (id_rt_i),
        .o_hz          (w_hz)
    );

    // A flushed instruction is discarded, so it never needs to wait.
    assign stall_o  = !flush_i && (((r_state == ST_RUN) && w_hz) || (r_state == ST_STALL));
    assign w_bubble = flush_i || stall_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_hz && (STALL_CYCLES > 1)) begin
                r_state <= ST_STALL;
                r_cnt   <= 2'(STALL_CYCLES - 1);
            end
        end else begin
            r_cnt <= r_cnt - 2'd1;
            if (r_cnt == 2'd1) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Every edge loads either the whole ID bundle or a complete bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_pc4     <= '0;
            r_ctrl    <= CTRL_BUBBLE;
        end else if (w_bubble) begin
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_pc4     <= '0;
            r_ctrl    <= CTRL_BUBBLE;
        end else begin
            r_rs      <= id_rs_i;
            r_rt      <= id_rt_i;
            r_rd      <= id_rd_i;
            r_rs_data <= id_rs_data_i;
            r_rt_data <= id_rt_data_i;
            r_imm     <= id_imm_i;
            r_pc4     <= id_pc4_i;
            r_ctrl    <= w_id_ctrl;
        end
    end

    assign ex_rs_o         = r_rs;
    assign ex_rt_o         = r_rt;
    assign ex_rd_o         = r_rd;
    assign ex_rs_data_o    = r_rs_data;
    assign ex_rt_data_o    = r_rt_data;
    assign ex_imm_o        = r_imm;
    assign ex_pc4_o        = r_pc4;
    assign ex_reg_write_o  = r_ctrl.reg_write;
    assign ex_mem_to_reg_o = r_ctrl.mem_to_reg;
    assign ex_mem_read_o   = r_ctrl.mem_read;
    assign ex_mem_write_o  = r_ctrl.mem_write;
    assign ex_alu_src_o    = r_ctrl.alu_src;
    assign ex_reg_dst_o    = r_ctrl.reg_dst;
    assign ex_branch_o     = r_ctrl.branch;
    assign ex_alu_op_o     = r_ctrl.alu_op;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register combined with load-use hazard interlock for the 5-stage MIPS pipeline.
- Latches decoded operands, immediates and control from ID and presents the EX-stage copies.
- ex_rs_o and ex_rt_o drive the Forwarding_Unit rs/rt compare inputs.
- Detects load-use hazards, stalls PC and IF/ID, and injects bubbles.
- Squashes its contents on a branch flush.

Parameters:
- DATA_W, 32, operand, immediate and PC width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (range 1..3; values >1 cover slow data memory).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_rs_i, id_rt_i, id_rd_i  in  5 each  ID-stage register specifiers.
- id_rs_data_i, id_rt_data_i  in  DATA_W  register file read data.
- id_imm_i  in  DATA_W  sign-extended immediate.
- id_pc4_i  in  DATA_W  PC+4.
- id_reg_write_i, id_mem_to_reg_i, id_mem_read_i, id_mem_write_i, id_alu_src_i, id_reg_dst_i, id_branch_i  in  1 each  decoder control.
- id_alu_op_i  in  3  ALU op class.
- flush_i  in  1  branch taken, resolved downstream.
- stall_o  out  1  high: hold PC and IF/ID.
- ex_rs_o, ex_rt_o, ex_rd_o  out  5 each  registered specifiers.
- ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o  out  DATA_W  registered data.
- ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o  out  1 each  registered control.
- ex_alu_op_o  out  3  registered ALU op.

Behaviour:
- Reset (rst_i low, asynchronous): all ex_* outputs 0, stall counter 0, FSM to RUN, stall_o 0.
- Latency: one cycle, ID to ex_*, when no hazard and no flush.
- Hazard condition (combinational, in RUN):
  - hz = ex_mem_read_o & ex_rt_o != 0 & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i).
  - rt is compared even for I-type; the resulting conservative stall is accepted.
- FSM states RUN and STALL, with a 2-bit counter cnt.
- RUN, hz=1, flush_i=0:
  - stall_o=1 in the same cycle.
  - Next edge: bubble loaded (all control outputs 0, specifiers 0, data outputs 0).
  - If STALL_CYCLES>1, go to STALL with cnt=STALL_CYCLES-1; otherwise stay in RUN.
- STALL:
  - stall_o=1 and a bubble is loaded every edge.
  - cnt decrements each edge; at cnt==1 the next state is RUN.
  - hz is not re-evaluated in STALL, because the load has already left EX.
- RUN, hz=0: normal capture of all id_* inputs.
- Flush has top priority:
  - flush_i=1: next edge loads a bubble, FSM returns to RUN, cnt=0.
  - stall_o is forced 0 in that cycle even if hz=1; the squashed instruction needs no stall.
- Bubble definition: every ex_* control output 0. Specifiers are zeroed so the Forwarding_Unit never matches a bubble.
- No partial capture: an edge loads either all id_* fields or a complete bubble.
- Reset mid-stall: immediate return to RUN with stall_o=0.
- Back-to-back loads with a dependent third instruction: each hazard is detected independently when its load reaches EX. There is no lost or doubled stall.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W.
  - REG_W=5.
  - ALU_OP_W=3.
  - typedef ctrl_t, the packed struct of the eight control fields.
  - constant CTRL_BUBBLE = '0.
- One natural sub-module: hazard_detect. It is the combinational hz equation only.
- Register bank and FSM stay in id_ex_stage.

Test Plan:
- Reset: hold rst_i low mid-cycle with a nonzero ID -> all ex_* 0 and stall_o 0 asynchronously; after release, a lw $8 in ID appears on ex_* one edge later.
- Load-use: lw $8 in EX (ex_mem_read_o=1, ex_rt_o=8) with add $9,$8,$10 in ID -> stall_o=1 that cycle; next edge ex_reg_write_o=0 and ex_rs_o=0; the following edge captures add with ex_rs_o=8.
- No false hazard: lw $0 in EX, id_rs_i=0 -> stall_o=0. lw $8 with ID using $9/$10 -> stall_o=0.
- STALL_CYCLES=3: same load-use -> stall_o high for exactly 3 cycles, 3 consecutive bubbles, then the dependent instruction is captured.
- Flush: flush_i=1 while hz=1 -> stall_o=0, next ex_* is a bubble, FSM in RUN. Flush during STALL (STALL_CYCLES=3, cycle 2) -> stall ends immediately.
- Back-to-back: lw $8; lw $9,0($8); add $10,$9,$9 -> two separate one-cycle stalls, each followed by correct capture.
